// File: rtl/cordic_ci_sequencer_pkg.sv
// cordic_pkg: shared widths, constants and FSM state type for the
// CORDIC custom-instruction sequencer.
package cordic_pkg;

   localparam int FX_W    = 22;            // fixed angle width (Q2.20)
   localparam int FX_FRAC = 20;            // fractional bits of the fixed angle
   localparam int ITER_W  = 5;             // iteration index width
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      LOAD,
      ITER,
      PACK,
      DONE
   } state_e;

endpackage

// File: rtl/cordic_ci_sequencer_if.sv
// Nios II custom-instruction handshake: start/dataa from the CPU,
// done/result back to it.
interface cordic_ci_sequencer_if;

   logic        start;
   logic [31:0] dataa;
   logic        done;
   logic [31:0] result;

   // CPU side
   modport master (output start, output dataa, input done, input result);
   // accelerator side
   modport slave  (input start, input dataa, output done, output result);

endinterface

// File: rtl/cordic_ci_sequencer_float_to_fixed.sv
// float_to_fixed: IEEE-754 single to signed Q2.20, magnitude truncated
// toward zero, wrapped to 22 bits. Zero/denormal inputs give 0.
module float_to_fixed
   import cordic_pkg::*;
(
   input  logic [31:0]     f_i,
   output logic [FX_W-1:0] fx_o
);

   logic [7:0]      expo;
   logic [63:0]     mant;
   logic [FX_W-1:0] mag;

   assign expo = f_i[30:23];
   assign mant = {40'd0, 1'b1, f_i[22:0]};

   // Value = mant * 2^(expo-150); scaled by 2^20 this is a shift by expo-130.
   always_comb begin
      // NOTE: default every combinational output first so no path infers a latch.
      mag = '0;
      if (expo == 8'd0) begin
         mag = '0;
      end else if (expo >= 8'd130) begin
         mag = FX_W'(mant << (expo - 8'd130));
      end else begin
         mag = FX_W'(mant >> (8'd130 - expo));
      end
   end

   assign fx_o = f_i[31] ? (~mag + FX_W'(1)) : mag;

endmodule

// File: rtl/cordic_ci_sequencer.sv
// cordic_ci_sequencer: multi-cycle Nios II custom-instruction controller.
// Converts the float angle to Q2.20, drives load/step/iter to an external
// CORDIC stage, waits for the packer, then returns its float with done.
// Optional: define CORDIC_RANGE_CHECK_EN to short-circuit NaN/Inf and
// |angle| >= 2.0 straight to a quiet-NaN result.
module cordic_ci_sequencer
   import cordic_pkg::*;
#(
   parameter int N_ITER   = 16,
   parameter int PACK_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clk_en,
   cordic_ci_sequencer_if.slave  nios,
   output logic [FX_W-1:0]       fx_angle,
   output logic                  dp_load,
   output logic                  dp_step,
   output logic [ITER_W-1:0]     dp_iter,
   input  logic [31:0]           dp_result
);

   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N_ITER - 1);
   localparam logic [2:0]        PACK_LAST = 3'((PACK_LAT > 0) ? PACK_LAT - 1 : 0);

   state_e            state_q;
   logic [31:0]       op_q;
   logic [FX_W-1:0]   fx_q;
   logic [FX_W-1:0]   fx_d;
   logic              done_q;
   logic [31:0]       result_q;
   logic              load_q;
   logic              step_q;
   logic [ITER_W-1:0] iter_q;
   logic [2:0]        pack_q;
   logic              oor;

   float_to_fixed u_f2f (
      .f_i  (op_q),
      .fx_o (fx_d)
   );

`ifdef CORDIC_RANGE_CHECK_EN
   // Biased exponent >= 128 means |angle| >= 2.0; this also covers NaN/Inf (0xFF).
   assign oor = (op_q[30:23] >= 8'd128);
`else
   assign oor = 1'b0;
`endif

   // Sequencer FSM with all handshake and datapath controls registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         fx_q     <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         load_q   <= 1'b0;
         step_q   <= 1'b0;
         iter_q   <= '0;
         pack_q   <= '0;
      end else if (clk_en) begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         load_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (nios.start) begin
                  op_q    <= nios.dataa;
                  state_q <= CONVERT;
               end
            end
            CONVERT: begin
               fx_q <= fx_d;
               if (oor) begin
                  result_q <= QNAN;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  load_q  <= 1'b1;
                  iter_q  <= '0;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               step_q  <= 1'b1;
               state_q <= ITER;
            end
            ITER: begin
               if (iter_q == ITER_LAST) begin
                  step_q <= 1'b0;
                  if (PACK_LAT == 0) begin
                     result_q <= dp_result;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     pack_q  <= '0;
                     state_q <= PACK;
                  end
               end else begin
                  iter_q <= iter_q + ITER_W'(1);
               end
            end
            PACK: begin
               if (pack_q == PACK_LAST) begin
                  result_q <= dp_result;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  pack_q <= pack_q + 3'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign nios.done   = done_q;
   assign nios.result = result_q;
   assign fx_angle    = fx_q;
   assign dp_load     = load_q;
   assign dp_step     = step_q;
   assign dp_iter     = iter_q;

endmodule

// File: tb/tb_cordic_ci_sequencer.sv
// Self-checking bench for cordic_ci_sequencer with a stub datapath.
// Edge numbering: the edge that samples start is edge 1.
module tb_cordic_ci_sequencer;
   import cordic_pkg::*;

   localparam int N_ITER   = 16;
   localparam int PACK_LAT = 1;
   localparam int LAT      = N_ITER + PACK_LAT + 3;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              clk_en = 1'b1;
   logic [FX_W-1:0]   fx_angle;
   logic              dp_load;
   logic              dp_step;
   logic [ITER_W-1:0] dp_iter;
   logic [31:0]       dp_result = '0;

   int checks = 0;
   int errors = 0;

   // observations from the most recent transaction
   int          o_load_edge, o_steps, o_done_edge, o_done_cnt, o_done2_edge;
   int          o_iter_err, o_fx_unstable, o_freeze_err;
   logic [31:0] o_res, o_res2;
   logic [FX_W-1:0] o_fx;

   cordic_ci_sequencer_if nios_if ();

   cordic_ci_sequencer #(.N_ITER(N_ITER), .PACK_LAT(PACK_LAT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clk_en    (clk_en),
      .nios      (nios_if),
      .fx_angle  (fx_angle),
      .dp_load   (dp_load),
      .dp_step   (dp_step),
      .dp_iter   (dp_iter),
      .dp_result (dp_result)
   );

   always #5 clk = ~clk;

   // Reference: angle * 2^20, truncated toward zero, two's complement in 22 bits.
   function automatic logic [FX_W-1:0] model_fx(input logic [31:0] f);
      real v;
      int  e;
      int  iv;
      e = int'(f[30:23]);
      if (e == 0) return '0;
      v = real'(int'({1'b1, f[22:0]}));
      for (int i = 0; i < e - 150 + FX_FRAC; i++) v = v * 2.0;
      for (int i = 0; i < 150 - FX_FRAC - e; i++) v = v / 2.0;
      iv = $rtoi(v);
      if (f[31]) iv = -iv;
      return iv[FX_W-1:0];
   endfunction

   // Random angle with |angle| < 2.0 so it is in range for every build.
   function automatic logic [31:0] rand_angle();
      logic [31:0] r;
      r = $urandom;
      r[30:23] = 8'($urandom_range(127, 100));
      return r;
   endfunction

   // Drive one transaction and observe the datapath/handshake for 'window' edges.
   task automatic run_txn(input logic [31:0] a, input logic [31:0] stub,
                          input int freeze_edge, input int restart_edge,
                          input logic b2b, input logic [31:0] a2,
                          input logic [31:0] stub2, input int window);
      int exp_iter;
      int second_start;
      logic en_k;
      logic [ITER_W-1:0] last_iter;
      o_load_edge = -1; o_steps = 0; o_done_edge = -1; o_done_cnt = 0;
      o_done2_edge = -1; o_iter_err = 0; o_fx_unstable = 0; o_freeze_err = 0;
      o_res = '0; o_res2 = '0; o_fx = '0;
      exp_iter = 0; second_start = -1; last_iter = dp_iter;
      dp_result = stub;
      nios_if.dataa = a;
      nios_if.start = 1'b1;
      for (int k = 1; k <= window; k++) begin
         @(negedge clk);
         en_k = clk_en;
         if (k == 1) nios_if.start = 1'b0;
         if (en_k) begin
            if (dp_load) begin
               if (o_load_edge < 0) o_load_edge = k;
               o_fx = fx_angle;
               exp_iter = 0;
            end
            if (dp_step) begin
               if (dp_iter !== exp_iter[ITER_W-1:0]) o_iter_err++;
               if (fx_angle !== o_fx) o_fx_unstable++;
               exp_iter++;
               o_steps++;
            end
            if (nios_if.done) begin
               o_done_cnt++;
               if (o_done_edge < 0) begin
                  o_done_edge = k;
                  o_res = nios_if.result;
               end else if (o_done2_edge < 0) begin
                  o_done2_edge = k;
                  o_res2 = nios_if.result;
               end
            end
         end else if (dp_iter !== last_iter) begin
            o_freeze_err++;
         end
         last_iter = dp_iter;
         if (k == freeze_edge) clk_en = 1'b0;
         if (k == freeze_edge + 5) clk_en = 1'b1;
         if (k == restart_edge) begin
            nios_if.start = 1'b1;
            nios_if.dataa = ~a;
         end
         if (k == restart_edge + 1) nios_if.start = 1'b0;
         if (k == second_start) nios_if.start = 1'b0;
         if (b2b && o_done_edge > 0 && k == o_done_edge + 1) begin
            nios_if.start = 1'b1;
            nios_if.dataa = a2;
            dp_result = stub2;
            second_start = k + 1;
         end
      end
   endtask

   // Checks common to every in-range single transaction.
   task automatic check_normal(input string tag, input logic [31:0] a,
                               input logic [31:0] stub, input int done_at);
      checks++;
      if (o_fx !== model_fx(a)) begin
         errors++; $display("FAIL %s fx_angle: got %h expected %h", tag, o_fx, model_fx(a));
      end
      checks++;
      if (o_load_edge !== 2) begin
         errors++; $display("FAIL %s dp_load edge: got %0d expected 2", tag, o_load_edge);
      end
      checks++;
      if (o_steps !== N_ITER) begin
         errors++; $display("FAIL %s dp_step count: got %0d expected %0d", tag, o_steps, N_ITER);
      end
      checks++;
      if (o_iter_err !== 0 || o_fx_unstable !== 0) begin
         errors++; $display("FAIL %s iter sequence: got %0d bad iters, %0d fx changes expected 0", tag, o_iter_err, o_fx_unstable);
      end
      checks++;
      if (o_done_edge !== done_at) begin
         errors++; $display("FAIL %s done edge: got %0d expected %0d", tag, o_done_edge, done_at);
      end
      checks++;
      if (o_done_cnt !== 1) begin
         errors++; $display("FAIL %s done count: got %0d expected 1", tag, o_done_cnt);
      end
      checks++;
      if (o_res !== stub) begin
         errors++; $display("FAIL %s result: got %h expected %h", tag, o_res, stub);
      end
   endtask

   task automatic test_reset();
      #23;
      checks++;
      if ({nios_if.done, nios_if.result, fx_angle, dp_load, dp_step, dp_iter} !== '0) begin
         errors++; $display("FAIL reset outputs: got %h/%h/%h/%b/%b/%h expected all 0",
                            nios_if.done, nios_if.result, fx_angle, dp_load, dp_step, dp_iter);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_zero();
      run_txn(32'h0000_0000, 32'h3F80_0000, -1, -1, 1'b0, '0, '0, 30);
      check_normal("zero", 32'h0000_0000, 32'h3F80_0000, LAT);
      checks++;
      if (o_fx !== 22'h000000) begin
         errors++; $display("FAIL zero fx const: got %h expected 000000", o_fx);
      end
   endtask

   task automatic test_neg_one();
      run_txn(32'hBF80_0000, 32'hC0A0_1234, -1, -1, 1'b0, '0, '0, 30);
      check_normal("neg_one", 32'hBF80_0000, 32'hC0A0_1234, LAT);
      checks++;
      if (o_fx !== 22'h300000) begin
         errors++; $display("FAIL neg_one fx const: got %h expected 300000", o_fx);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, stub;
      for (int t = 0; t < 6; t++) begin
         a = rand_angle();
         stub = $urandom;
         run_txn(a, stub, -1, -1, 1'b0, '0, '0, 26);
         check_normal("random", a, stub, LAT);
         dp_result = ~stub;
         repeat (3) @(negedge clk);
         checks++;
         if (nios_if.result !== stub) begin
            errors++; $display("FAIL result hold: got %h expected %h", nios_if.result, stub);
         end
      end
   endtask

   task automatic test_start_ignored();
      logic [31:0] a, stub;
      a = rand_angle();
      stub = $urandom;
      run_txn(a, stub, -1, 8, 1'b0, '0, '0, 45);
      check_normal("start_in_iter", a, stub, LAT);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, a2, stub, stub2;
      a = rand_angle(); a2 = rand_angle();
      stub = $urandom; stub2 = $urandom;
      run_txn(a, stub, -1, -1, 1'b1, a2, stub2, 2 * LAT + 8);
      checks++;
      if (o_done_edge !== LAT || o_res !== stub) begin
         errors++; $display("FAIL b2b first: got edge %0d res %h expected edge %0d res %h", o_done_edge, o_res, LAT, stub);
      end
      checks++;
      if (o_done2_edge !== 2 * LAT + 1 || o_done_cnt !== 2) begin
         errors++; $display("FAIL b2b second edge: got %0d (count %0d) expected %0d (count 2)", o_done2_edge, o_done_cnt, 2 * LAT + 1);
      end
      checks++;
      if (o_res2 !== stub2 || o_fx !== model_fx(a2)) begin
         errors++; $display("FAIL b2b second data: got %h/%h expected %h/%h", o_res2, o_fx, stub2, model_fx(a2));
      end
      checks++;
      if (o_steps !== 2 * N_ITER || o_iter_err !== 0) begin
         errors++; $display("FAIL b2b steps: got %0d (%0d bad) expected %0d", o_steps, o_iter_err, 2 * N_ITER);
      end
   endtask

   task automatic test_clk_en();
      logic [31:0] a, stub;
      a = rand_angle();
      stub = $urandom;
      run_txn(a, stub, 8, -1, 1'b0, '0, '0, 36);
      check_normal("clk_en", a, stub, LAT + 5);
      checks++;
      if (o_freeze_err !== 0) begin
         errors++; $display("FAIL clk_en freeze: got %0d dp_iter changes expected 0", o_freeze_err);
      end
   endtask

   task automatic test_reset_mid();
      int n_done;
      nios_if.dataa = rand_angle();
      nios_if.start = 1'b1;
      @(negedge clk);
      nios_if.start = 1'b0;
      repeat (7) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({nios_if.done, nios_if.result, fx_angle, dp_load, dp_step, dp_iter} !== '0) begin
         errors++; $display("FAIL reset mid outputs: got %h/%h/%h/%b/%b/%h expected all 0",
                            nios_if.done, nios_if.result, fx_angle, dp_load, dp_step, dp_iter);
      end
      @(negedge clk);
      reset_n = 1'b1;
      n_done = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (nios_if.done || dp_step || dp_load) n_done++;
      end
      checks++;
      if (n_done !== 0 || nios_if.result !== '0) begin
         errors++; $display("FAIL reset idle: got %0d activity cycles result %h expected 0/0", n_done, nios_if.result);
      end
   endtask

`ifdef CORDIC_RANGE_CHECK_EN
   task automatic test_range();
      run_txn(32'h7F80_0000, 32'h1234_5678, -1, -1, 1'b0, '0, '0, 12);
      checks++;
      if (o_steps !== 0 || o_load_edge !== -1) begin
         errors++; $display("FAIL range datapath: got %0d steps load edge %0d expected 0/-1", o_steps, o_load_edge);
      end
      checks++;
      if (o_done_edge !== 2 || o_done_cnt !== 1) begin
         errors++; $display("FAIL range done: got edge %0d count %0d expected 2/1", o_done_edge, o_done_cnt);
      end
      checks++;
      if (o_res !== QNAN) begin
         errors++; $display("FAIL range result: got %h expected %h", o_res, QNAN);
      end
   endtask
`endif

   initial begin
      nios_if.start = 1'b0;
      nios_if.dataa = '0;
      test_reset();
      test_zero();
      test_neg_one();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_clk_en();
      test_reset_mid();
`ifdef CORDIC_RANGE_CHECK_EN
      test_range();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
